// File: rtl/data_sram_like_slave.sv
// Responder for the sram-like data bus: word memory with byte-lane writes,
// up to DEPTH outstanding requests, in-order responses after LATENCY cycles.
module data_sram_like_slave #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_INIT = LW'(LATENCY - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [31:0]       mem [2**ADDR_W];
  logic              q_rd   [DEPTH];
  logic [31:0]       q_data [DEPTH];
  logic [LW-1:0]     q_cnt  [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        strb;
  logic              accept;
  logic              pop;
  logic              unused_addr_hi;

  // Pointers wrap explicitly so non-power-of-two or single-entry depths stay in range
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Upper address bits alias onto the same words
  assign idx            = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^data_sram_addr[31:ADDR_W+2];

  // A pop in the same cycle never frees a slot for the push
  assign data_sram_addr_ok = data_sram_req && (count < DEPTH_C);
  assign accept            = data_sram_addr_ok;

  assign data_sram_data_ok = (count != '0) && (q_cnt[head] == '0);
  assign pop               = data_sram_data_ok;
  assign data_sram_rdata   = (data_sram_data_ok && q_rd[head]) ? q_data[head] : 32'h0;

  // Lane strobes; misaligned half/word accesses write nothing
  always_comb begin
    strb = 4'b0000;
    case (data_sram_size)
      2'd0:    strb = 4'b0001 << data_sram_addr[1:0];
      2'd1:    if (!data_sram_addr[0]) strb = data_sram_addr[1] ? 4'b1100 : 4'b0011;
      default: if (data_sram_addr[1:0] == 2'b00) strb = 4'b1111;
    endcase
  end

  // Memory array is not reset; writes commit at the accept edge
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Outstanding-response FIFO: reads snapshot the word before this edge's write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= 1'b0;
        q_data[i] <= 32'h0;
        q_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - LW'(1);
      end
      if (accept) begin
        q_rd[tail]   <= !data_sram_wr;
        q_data[tail] <= data_sram_wr ? 32'h0 : mem[idx];
        q_cnt[tail]  <= LAT_INIT;
        tail         <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Bench for data_sram_like_slave: two instances (LATENCY 2 and 6), a
// transaction-level model of due times and memory words, and directed cases.
module tb_data_sram_like_slave;
  localparam int AW = 12, D = 4, LAT0 = 2, LAT1 = 6, NLOG = 1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req [2];
  logic        wr [2];
  logic [1:0]  size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          acc_n [2];
  int          rsp_n [2];
  int          m_due [2][NLOG];
  logic [31:0] m_dat [2][NLOG];
  logic [31:0] m_mem [2][4096];
  int          rlog_n [2];
  int          rlog_cyc [2][NLOG];
  logic [31:0] rlog_dat [2][NLOG];
  int          exp_acc [8] = '{0, 1, 2, 3, 7, 8, 9, 10};
  int          exp_rsp [8] = '{6, 7, 8, 9, 13, 14, 15, 16};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_like_slave #(.ADDR_W(AW), .DEPTH(D), .LATENCY(LAT0)) u0 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_size(size[0]), .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_addr_ok(addr_ok[0]), .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0]));

  data_sram_like_slave #(.ADDR_W(AW), .DEPTH(D), .LATENCY(LAT1)) u1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_size(size[1]), .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_addr_ok(addr_ok[1]), .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Writes replace the addressed bytes of naturally aligned accesses only
  function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    r  = old;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if ((int'(off) % nb) == 0)
      for (int b = int'(off); b < int'(off) + nb; b++) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Compare process: the n-th accepted request is due LATENCY cycles after its
  // accept and is answered no earlier than that, one per cycle, in order
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin : per_dut
      int          n_out;
      logic        e_dok;
      logic [31:0] e_rd;
      logic        e_aok;
      int          widx;
      if (!resetn) rsp_n[k] = acc_n[k];
      n_out = acc_n[k] - rsp_n[k];
      e_dok = resetn && (n_out > 0) && (m_due[k][rsp_n[k] % NLOG] <= cyc);
      e_rd  = e_dok ? m_dat[k][rsp_n[k] % NLOG] : 32'h0;
      e_aok = req[k] && (n_out < D);
      chk($sformatf("data_ok[%0d]", k), data_ok[k], e_dok);
      chk($sformatf("rdata[%0d]", k), rdata[k], e_rd);
      chk($sformatf("addr_ok[%0d]", k), addr_ok[k], e_aok);
      if (data_ok[k]) begin
        rlog_cyc[k][rlog_n[k] % NLOG] = cyc;
        rlog_dat[k][rlog_n[k] % NLOG] = rdata[k];
        rlog_n[k]++;
      end
      if (e_dok) rsp_n[k]++;
      if (resetn && e_aok) begin
        widx = int'(addr[k][13:2]);
        if (wr[k]) begin
          m_mem[k][widx] = apply_write(m_mem[k][widx], size[k], addr[k][1:0], wdata[k]);
          m_dat[k][acc_n[k] % NLOG] = 32'h0;
        end else begin
          m_dat[k][acc_n[k] % NLOG] = m_mem[k][widx];
        end
        m_due[k][acc_n[k] % NLOG] = cyc + lat(k);
        acc_n[k]++;
      end
    end
  end

  // Enters and leaves at 1 time unit after a rising edge; c = accept cycle
  task automatic issue(input int k, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output int c);
    int t;
    t = 0;
    c = -1;
    wr[k] = w; size[k] = sz; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    while (c == -1) begin
      @(negedge clk);
      if (addr_ok[k]) c = cyc;
      else if (++t > 60) begin
        expired("issue");
        c = -2;
      end
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (acc_n[k] != rsp_n[k] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (acc_n[k] != rsp_n[k]) expired("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    int c, c1, m, n, t;
    int acc_c [8];
    logic [31:0] a;
    begin : watchdog_fork
      fork
        begin
          #500000;
          $display("FAIL watchdog: simulation did not complete");
          $fatal(1, "watchdog");
        end
      join_none
    end
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd0; addr[k] = 32'h0; wdata[k] = 32'h0;
      acc_n[k] = 0; rsp_n[k] = 0; rlog_n[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset data_ok", data_ok[0], 1'b0);
    chk("reset rdata", rdata[1], 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) issue(k, 1'b1, 2'd2, i * 4, $urandom, c);
      drain(k);
    end

    // Word write then read, LATENCY 2
    m = rlog_n[0];
    issue(0, 1'b1, 2'd2, 32'h10, 32'h11223344, c1);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, c);
    drain(0);
    chk("t1 resp count", rlog_n[0] - m, 2);
    chk("t1 second accept", c - c1, 1);
    chk("t1 wr resp cycle", rlog_cyc[0][m % NLOG] - c1, 2);
    chk("t1 rd resp cycle", rlog_cyc[0][(m + 1) % NLOG] - c1, 3);
    chk("t1 wr rdata", rlog_dat[0][m % NLOG], 32'h0);
    chk("t1 rd rdata", rlog_dat[0][(m + 1) % NLOG], 32'h11223344);

    // Byte and half lane writes
    issue(0, 1'b1, 2'd0, 32'h11, 32'h0000AB00, c);
    issue(0, 1'b1, 2'd1, 32'h12, 32'hCDEF0000, c);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, c);
    drain(0);
    chk("t2 merged word", rlog_dat[0][(rlog_n[0] - 1) % NLOG], 32'hCDEFAB44);

    // Misaligned half write is answered but leaves memory alone
    m = rlog_n[0];
    issue(0, 1'b1, 2'd1, 32'h13, 32'hFFFFFFFF, c);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, c);
    drain(0);
    chk("t4 resp count", rlog_n[0] - m, 2);
    chk("t4 unchanged", rlog_dat[0][(m + 1) % NLOG], 32'hCDEFAB44);

    // Upper address bits alias
    issue(0, 1'b1, 2'd2, 32'h00004010, 32'h5A5A1234, c);
    issue(0, 1'b0, 2'd2, 32'h00000010, 32'h0, c);
    drain(0);
    chk("t6 alias", rlog_dat[0][(rlog_n[0] - 1) % NLOG], 32'h5A5A1234);

    // Held read requests against DEPTH 4, LATENCY 6
    m = rlog_n[1];
    n = 0; t = 0;
    wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h0; req[1] = 1'b1;
    while (n < 8 && t < 40) begin
      @(negedge clk);
      if (addr_ok[1]) begin
        acc_c[n] = cyc;
        n++;
      end
      t++;
      @(posedge clk); #1;
      addr[1] = n * 4;
    end
    req[1] = 1'b0;
    if (n < 8) expired("t3 accepts");
    drain(1);
    chk("t3 resp count", rlog_n[1] - m, 8);
    for (int i = 1; i < 8; i++) chk($sformatf("t3 accept %0d", i), acc_c[i] - acc_c[0], exp_acc[i]);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3 resp %0d", i), rlog_cyc[1][(m + i) % NLOG] - acc_c[0], exp_rsp[i]);

    // Reset while reads are outstanding
    for (int i = 0; i < 3; i++) issue(1, 1'b0, 2'd2, i * 4, 32'h0, c);
    t = 0;
    @(negedge clk);
    while (!data_ok[1] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!data_ok[1]) expired("t5 first data_ok");
    #1 resetn = 1'b0;
    #1 chk("t5 data_ok drops", data_ok[1], 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    m = rlog_n[1];
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("t5 no stale", rlog_n[1] - m, 0);
    issue(1, 1'b0, 2'd2, 32'h8, 32'h0, c);
    drain(1);
    chk("t5 fresh latency", rlog_cyc[1][m % NLOG] - c, LAT1);

    // Randomised traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        a = ($urandom & 32'hFFFFC000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        issue(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, c);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      drain(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
